// File: rtl/common_bus_datapath.sv
// common_bus_datapath
//
// Datapath half of the 8-bit common-bus CPU.
//
// The block holds the following state:
//   - instruction register (IR)
//   - program counter (PC)
//   - register file
//   - register-select field
//   - ALU source registers
//   - zero and carry flags
//
// All of these registers read from, or feed, one shared 8-bit bus.
// The microcode sequencer supplies the bus source select and the load
// enables each cycle. The datapath itself contains no sequencing.
//
// Ports:
//   clock              rising-edge system clock
//   reset_n            asynchronous active-low reset; clears all state
//   data_bus_sel       bus source select (data_bus_t)
//   pc_load_en         PC  <= bus
//   ir_load_en         IR  <= instr_in
//   rf_write_read      1: rf[sel] <= bus (flags update on ALU_BUS), 0: read only
//   alu_src1_load_en   src1 <= bus
//   alu_src2_load_en   src2 <= bus
//   sel_field_load_en  sel  <= bus[2:0]
//   instr_in           16-bit instruction word fetched at pc_out
//   imm_instruction    IR[13], returned to the sequencer
//   pc_out             current PC
//   bus_out            current bus value
//   flag_z, flag_c     registered zero and carry/borrow flags
//
// Optional build macro:
//   RF_R0_ZERO_EN      when defined, r0 reads as 0x00 and writes to r0
//                      are dropped (the flags still update)

package internal_defines_pkg;
    typedef enum logic [2:0] {
        ZERO      = 3'd0,
        IR_R1     = 3'd1,
        IR_RD     = 3'd2,
        IR_R2     = 3'd3,
        RF        = 3'd4,
        ALU_BUS   = 3'd5,
        PC_PLUS_4 = 3'd6
    } data_bus_t;
endpackage

module common_bus_datapath
    import internal_defines_pkg::*;
#(
    parameter int unsigned RF_DEPTH = 8,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  data_bus_t   data_bus_sel,
    input  logic        pc_load_en,
    input  logic        ir_load_en,
    input  logic        rf_write_read,
    input  logic        alu_src1_load_en,
    input  logic        alu_src2_load_en,
    input  logic        sel_field_load_en,
    input  logic [15:0] instr_in,
    output logic        imm_instruction,
    output logic [7:0]  pc_out,
    output logic [7:0]  bus_out,
    output logic        flag_z,
    output logic        flag_c
);

    logic [15:0] ir;
    logic [7:0]  pc;
    logic [2:0]  sel;
    logic [7:0]  src1;
    logic [7:0]  src2;
    logic [7:0]  rf [RF_DEPTH];

    logic [7:0]  bus;
    logic [7:0]  rf_rdata;
    logic [7:0]  alu_result;
    logic        alu_carry;
    logic [8:0]  sum9;
    logic [8:0]  diff9;

    // Register-file read port. Selects that fall outside RF_DEPTH read as zero.
    always_comb begin
        rf_rdata = '0;
        for (int unsigned i = 0; i < RF_DEPTH; i++) begin
            if (sel == 3'(i)) begin
                rf_rdata = rf[i];
            end
        end
`ifdef RF_R0_ZERO_EN
        if (sel == 3'd0) begin
            rf_rdata = '0;
        end
`endif
    end

    // ALU. For SUB, bit 8 of the 9-bit difference is the borrow
    // (set when src1 < src2, unsigned).
    assign sum9  = {1'b0, src1} + {1'b0, src2};
    assign diff9 = {1'b0, src1} - {1'b0, src2};

    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        case (ir[15:14])
            2'b00: begin
                alu_result = sum9[7:0];
                alu_carry  = sum9[8];
            end
            2'b01: begin
                alu_result = diff9[7:0];
                alu_carry  = diff9[8];
            end
            2'b10: alu_result = src1 & src2;
            2'b11: alu_result = src1 ^ src2;
            default: begin
                alu_result = '0;
                alu_carry  = 1'b0;
            end
        endcase
    end

    // Shared bus multiplexer.
    always_comb begin
        bus = '0;
        case (data_bus_sel)
            ZERO:      bus = '0;
            IR_R1:     bus = {5'b0, ir[9:7]};
            IR_RD:     bus = {5'b0, ir[12:10]};
            IR_R2:     bus = ir[13] ? {ir[6], ir[6:0]} : {5'b0, ir[2:0]};
            RF:        bus = rf_rdata;
            ALU_BUS:   bus = alu_result;
            PC_PLUS_4: bus = pc + 8'(PC_STEP);
            default:   bus = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ir     <= '0;
            pc     <= '0;
            sel    <= '0;
            src1   <= '0;
            src2   <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            for (int unsigned i = 0; i < RF_DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (ir_load_en) begin
                ir <= instr_in;
            end
            if (pc_load_en) begin
                pc <= bus;
            end
            if (sel_field_load_en) begin
                sel <= bus[2:0];
            end
            if (alu_src1_load_en) begin
                src1 <= bus;
            end
            if (alu_src2_load_en) begin
                src2 <= bus;
            end
            if (rf_write_read) begin
                for (int unsigned i = 0; i < RF_DEPTH; i++) begin
`ifdef RF_R0_ZERO_EN
                    if (sel == 3'(i) && i != 0) begin
`else
                    if (sel == 3'(i)) begin
`endif
                        rf[i] <= bus;
                    end
                end
                if (data_bus_sel == ALU_BUS) begin
                    flag_z <= (alu_result == 8'h00);
                    flag_c <= alu_carry;
                end
            end
        end
    end

    assign imm_instruction = ir[13];
    assign pc_out          = pc;
    assign bus_out         = bus;

endmodule

// File: tb/tb_common_bus_datapath.sv
module tb_common_bus_datapath;
    import internal_defines_pkg::*;

    logic        clock;
    logic        reset_n;
    data_bus_t   data_bus_sel;
    logic        pc_load_en;
    logic        ir_load_en;
    logic        rf_write_read;
    logic        alu_src1_load_en;
    logic        alu_src2_load_en;
    logic        sel_field_load_en;
    logic [15:0] instr_in;
    logic        imm_instruction;
    logic [7:0]  pc_out;
    logic [7:0]  bus_out;
    logic        flag_z;
    logic        flag_c;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] EN_NONE = 6'b000000;
    localparam logic [5:0] EN_PC   = 6'b100000;
    localparam logic [5:0] EN_IR   = 6'b010000;
    localparam logic [5:0] EN_RF   = 6'b001000;
    localparam logic [5:0] EN_S1   = 6'b000100;
    localparam logic [5:0] EN_S2   = 6'b000010;
    localparam logic [5:0] EN_SEL  = 6'b000001;

    common_bus_datapath #(.RF_DEPTH(8), .PC_STEP(4)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .data_bus_sel      (data_bus_sel),
        .pc_load_en        (pc_load_en),
        .ir_load_en        (ir_load_en),
        .rf_write_read     (rf_write_read),
        .alu_src1_load_en  (alu_src1_load_en),
        .alu_src2_load_en  (alu_src2_load_en),
        .sel_field_load_en (sel_field_load_en),
        .instr_in          (instr_in),
        .imm_instruction   (imm_instruction),
        .pc_out            (pc_out),
        .bus_out           (bus_out),
        .flag_z            (flag_z),
        .flag_c            (flag_c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input data_bus_t s, input logic [5:0] en);
        data_bus_sel      = s;
        pc_load_en        = en[5];
        ir_load_en        = en[4];
        rf_write_read     = en[3];
        alu_src1_load_en  = en[2];
        alu_src2_load_en  = en[1];
        sel_field_load_en = en[0];
    endtask

    task automatic cyc(input data_bus_t s, input logic [5:0] en);
        drive(s, en);
        @(posedge clock);
        #1;
    endtask

    task automatic run_imm(input logic [15:0] instr);
        instr_in = instr;
        cyc(ZERO,      EN_IR);
        cyc(IR_R1,     EN_SEL);
        cyc(RF,        EN_S1);
        cyc(IR_R2,     EN_S2);
        cyc(IR_RD,     EN_SEL);
        cyc(ALU_BUS,   EN_RF);
        cyc(PC_PLUS_4, EN_PC);
        drive(ZERO, EN_NONE);
    endtask

    task automatic run_reg(input logic [15:0] instr);
        instr_in = instr;
        cyc(ZERO,      EN_IR);
        cyc(IR_R1,     EN_SEL);
        cyc(RF,        EN_S1);
        cyc(IR_R2,     EN_SEL);
        cyc(RF,        EN_S2);
        cyc(IR_RD,     EN_SEL);
        cyc(ALU_BUS,   EN_RF);
        cyc(PC_PLUS_4, EN_PC);
        drive(ZERO, EN_NONE);
    endtask

    // Point sel at register idx through IR.rd and place it on the bus.
    task automatic read_reg(input logic [2:0] idx, output logic [7:0] val);
        instr_in = {3'b000, idx, 10'b0};
        cyc(ZERO,  EN_IR);
        cyc(IR_RD, EN_SEL);
        drive(RF, EN_NONE);
        #1;
        val = bus_out;
        drive(ZERO, EN_NONE);
    endtask

    logic [7:0] v;

    initial begin
        reset_n  = 1'b0;
        instr_in = '0;
        drive(ZERO, EN_NONE);
        #12;
        check("reset_pc",  pc_out, 8'h00);
        check("reset_bus", bus_out, 8'h00);
        check("reset_z",   {7'b0, flag_z}, 8'h00);
        check("reset_c",   {7'b0, flag_c}, 8'h00);
        check("reset_imm", {7'b0, imm_instruction}, 8'h00);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // ADDI r1,r0,5
        instr_in = 16'h2405;
        cyc(ZERO, EN_IR);
        check("addi_imm_bit", {7'b0, imm_instruction}, 8'h01);
        drive(IR_R2, EN_NONE);
        #1;
        check("addi_imm_bus", bus_out, 8'h05);
        run_imm(16'h2405);
        check("addi_pc", pc_out, 8'h04);
        check("addi_z",  {7'b0, flag_z}, 8'h00);
        check("addi_c",  {7'b0, flag_c}, 8'h00);
        read_reg(3'd1, v);
        check("addi_r1", v, 8'h05);

        // SUB r2,r1,r1
        run_reg(16'h4881);
        check("sub_pc", pc_out, 8'h08);
        check("sub_z",  {7'b0, flag_z}, 8'h01);
        check("sub_c",  {7'b0, flag_c}, 8'h00);
        read_reg(3'd2, v);
        check("sub_r2", v, 8'h00);

        // ADDI r3,r1,-1
        instr_in = 16'h2CFF;
        cyc(ZERO, EN_IR);
        drive(IR_R2, EN_NONE);
        #1;
        check("addi_neg_bus", bus_out, 8'hFF);
        run_imm(16'h2CFF);
        check("addi_neg_c", {7'b0, flag_c}, 8'h01);
        check("addi_neg_z", {7'b0, flag_z}, 8'h00);
        read_reg(3'd3, v);
        check("addi_neg_r3", v, 8'h04);
        check("addi_neg_pc", pc_out, 8'h0C);

        // XOR r4,r1,r3: 5 ^ 4 = 1, carry cleared
        run_reg(16'hD083);
        check("xor_c", {7'b0, flag_c}, 8'h00);
        check("xor_z", {7'b0, flag_z}, 8'h00);
        read_reg(3'd4, v);
        check("xor_r4", v, 8'h01);

        // SUB r5,r3,r1: 4 - 5 borrows
        run_reg(16'h5581);
        check("sub_borrow_c", {7'b0, flag_c}, 8'h01);
        read_reg(3'd5, v);
        check("sub_borrow_r5", v, 8'hFF);

        // AND r6,r2,r5: 0 & 0xFF = 0
        run_reg(16'h9905);
        check("and_z", {7'b0, flag_z}, 8'h01);
        check("and_c", {7'b0, flag_c}, 8'h00);
        check("and_pc", pc_out, 8'h18);

        // ALU on the bus without a write leaves the flags alone.
        // src1 = 0xFF, src2 = 0x05, op = ADD gives 0x104.
        instr_in = 16'h0000;
        cyc(ZERO, EN_IR);
        read_reg(3'd5, v);
        cyc(RF, EN_S1);
        read_reg(3'd1, v);
        cyc(RF, EN_S2);
        drive(ALU_BUS, EN_NONE);
        #1;
        check("alu_bus_add", bus_out, 8'h04);
        cyc(ALU_BUS, EN_NONE);
        check("noflag_z", {7'b0, flag_z}, 8'h01);
        check("noflag_c", {7'b0, flag_c}, 8'h00);

        // An unused select encoding drives zero.
        drive(data_bus_t'(3'd7), EN_NONE);
        #1;
        check("bus_other", bus_out, 8'h00);

        // One bus value loaded into src1, src2 and sel together:
        // 3 + 3 = 6 on the ALU, and sel = 3 reads r3 = 4.
        instr_in = 16'h0C00;
        cyc(ZERO, EN_IR);
        cyc(IR_RD, EN_S1 | EN_S2 | EN_SEL);
        drive(ALU_BUS, EN_NONE);
        #1;
        check("multi_load_alu", bus_out, 8'h06);
        drive(RF, EN_NONE);
        #1;
        check("multi_load_sel", bus_out, 8'h04);

        // PC wrap: 0xFC + 4 -> 0x00
        instr_in = 16'h207C;
        cyc(ZERO, EN_IR);
        cyc(IR_R2, EN_PC);
        check("pc_load_fc", pc_out, 8'hFC);
        drive(PC_PLUS_4, EN_NONE);
        #1;
        check("pc_plus_bus", bus_out, 8'h00);
        cyc(PC_PLUS_4, EN_PC);
        check("pc_wrap", pc_out, 8'h00);

        // ADDI r0,r0,7: r0 behaviour depends on the build; the flags update either way.
        run_imm(16'h2007);
        check("r0_flag_z", {7'b0, flag_z}, 8'h00);
        read_reg(3'd0, v);
`ifdef RF_R0_ZERO_EN
        check("r0_read", v, 8'h00);
`else
        check("r0_read", v, 8'h07);
`endif

        // Reset asserted during the ALU write cycle of ADDI r7,r1,3.
        instr_in = 16'h3C83;
        cyc(ZERO,  EN_IR);
        cyc(IR_R1, EN_SEL);
        cyc(RF,    EN_S1);
        cyc(IR_R2, EN_S2);
        cyc(IR_RD, EN_SEL);
        drive(ALU_BUS, EN_RF);
        #1;
        check("pre_reset_bus", bus_out, 8'h08);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_pc",  pc_out, 8'h00);
        check("async_rst_bus", bus_out, 8'h00);
        check("async_rst_z",   {7'b0, flag_z}, 8'h00);
        check("async_rst_c",   {7'b0, flag_c}, 8'h00);
        check("async_rst_imm", {7'b0, imm_instruction}, 8'h00);
        @(posedge clock);
        #1;
        drive(ZERO, EN_NONE);
        reset_n = 1'b1;
        read_reg(3'd7, v);
        check("rst_r7", v, 8'h00);
        read_reg(3'd1, v);
        check("rst_r1", v, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
